// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared engine state type and channel-index sizing for dma_controller_mc
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } engine_state_e;

  // A single-channel build still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/dma_controller_mc_if.sv
// rtl/dma_controller_mc_if.sv - UART receive and memory write bundle of dma_controller_mc
interface dma_controller_mc_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic [NUM_CH*DATA_WIDTH-1:0] uart_data;
  logic [NUM_CH-1:0]            uart_data_valid;
  logic [NUM_CH-1:0]            uart_read_enable;
  logic [ADDR_WIDTH-1:0]        memory_write_address;
  logic [DATA_WIDTH-1:0]        memory_write_data;
  logic                         memory_write_enable;

  modport master (
    input  uart_data,
    input  uart_data_valid,
    output uart_read_enable,
    output memory_write_address,
    output memory_write_data,
    output memory_write_enable
  );

  modport slave (
    output uart_data,
    output uart_data_valid,
    input  uart_read_enable,
    input  memory_write_address,
    input  memory_write_data,
    input  memory_write_enable
  );

endinterface

// File: rtl/dma_rr_arbiter.sv
// rtl/dma_rr_arbiter.sv - combinational round-robin pick of the first requester at or after ptr
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_CH);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dma_controller_mc.sv
// rtl/dma_controller_mc.sv - NUM_CH UART-to-memory DMA channels sharing one byte-granular write engine
// DMA_CIRCULAR_EN adds the circular input for auto-reloading transfers.
module dma_controller_mc
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int SIZE_WIDTH = 8,
  parameter int NUM_CH     = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
`ifdef DMA_CIRCULAR_EN
  input  logic [NUM_CH-1:0]            circular,
`endif
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH-1:0]            abort,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] start_address,
  input  logic [NUM_CH*SIZE_WIDTH-1:0] transfer_size,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  dma_controller_mc_if.master          bus
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  engine_state_e         state;
  logic [IDX_W-1:0]      grant;
  logic [IDX_W-1:0]      rr_ptr;
  logic [NUM_CH-1:0]     start_q;
  logic [NUM_CH-1:0]     circ_q;
  logic [NUM_CH-1:0]     circ_in;
  logic [ADDR_WIDTH-1:0] base_q   [NUM_CH];
  logic [ADDR_WIDTH-1:0] offset_q [NUM_CH];
  logic [SIZE_WIDTH-1:0] size_q   [NUM_CH];
  logic [SIZE_WIDTH-1:0] remain_q [NUM_CH];
  logic [NUM_CH-1:0]     rd_en_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [NUM_CH-1:0]     start_edge;
  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [DATA_WIDTH-1:0] grant_data;

`ifdef DMA_CIRCULAR_EN
  assign circ_in = circular;
`else
  assign circ_in = '0;
`endif

  assign start_edge = start & ~start_q;
  assign req        = busy & ~abort;
  assign grant_data = bus.uart_data[grant*DATA_WIDTH +: DATA_WIDTH];

  assign bus.uart_read_enable     = rd_en_q;
  assign bus.memory_write_enable  = wr_en_q;
  assign bus.memory_write_address = wr_addr_q;
  assign bus.memory_write_data    = wr_data_q;

  dma_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      start_q   <= '0;
      circ_q    <= '0;
      busy      <= '0;
      done      <= '0;
      rd_en_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        base_q[c]   <= '0;
        offset_q[c] <= '0;
        size_q[c]   <= '0;
        remain_q[c] <= '0;
      end
    end else begin
      start_q <= start;

      for (int c = 0; c < NUM_CH; c++) begin
        // Circular channels report each finished pass as a one-cycle pulse.
        if (circ_q[c] && done[c]) begin
          done[c] <= 1'b0;
        end
        if (abort[c]) begin
          busy[c] <= 1'b0;
        end else if (start_edge[c] && !busy[c]) begin
          base_q[c]   <= start_address[c*ADDR_WIDTH +: ADDR_WIDTH];
          size_q[c]   <= transfer_size[c*SIZE_WIDTH +: SIZE_WIDTH];
          remain_q[c] <= transfer_size[c*SIZE_WIDTH +: SIZE_WIDTH];
          offset_q[c] <= '0;
          circ_q[c]   <= circ_in[c];
          busy[c]     <= (transfer_size[c*SIZE_WIDTH +: SIZE_WIDTH] != '0);
          done[c]     <= (transfer_size[c*SIZE_WIDTH +: SIZE_WIDTH] == '0);
        end
      end

      case (state)
        IDLE: begin
          if (arb_any) begin
            grant   <= arb_idx;
            rd_en_q <= arb_grant;
            state   <= READ;
          end
        end

        READ: begin
          // Abort beats a simultaneous valid: the byte is left in the UART.
          if (abort[grant]) begin
            rd_en_q <= '0;
            state   <= IDLE;
          end else if (bus.uart_data_valid[grant]) begin
            rd_en_q   <= '0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= base_q[grant] + offset_q[grant];
            wr_data_q <= grant_data;
            state     <= WRITE;
          end
        end

        WRITE: begin
          wr_en_q <= 1'b0;
          rr_ptr  <= (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + IDX_W'(1);
          state   <= IDLE;
          if (busy[grant] && !abort[grant]) begin
            offset_q[grant] <= offset_q[grant] + ADDR_WIDTH'(1);
            remain_q[grant] <= remain_q[grant] - SIZE_WIDTH'(1);
            if (remain_q[grant] == SIZE_WIDTH'(1)) begin
              done[grant] <= 1'b1;
              if (circ_q[grant]) begin
                offset_q[grant] <= '0;
                remain_q[grant] <= size_q[grant];
              end else begin
                busy[grant] <= 1'b0;
              end
            end
          end
        end

        default: begin
          rd_en_q <= '0;
          wr_en_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller_mc.sv
// tb/tb_dma_controller_mc.sv - randomized scoreboard bench for dma_controller_mc
// Exercises the DMA_CIRCULAR_EN section only when that macro is defined.
`timescale 1ns/1ps
module tb_dma_controller_mc;

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  abort = '0;
`ifdef DMA_CIRCULAR_EN
  logic [1:0]  circular = '0;
`endif
  logic [15:0] start_address = '0;
  logic [15:0] transfer_size = '0;
  logic [1:0]  busy;
  logic [1:0]  done;

  dma_controller_mc_if #(.NUM_CH(2), .DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  dma_controller_mc #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .SIZE_WIDTH (8),
    .NUM_CH     (2)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
`ifdef DMA_CIRCULAR_EN
    .circular      (circular),
`endif
    .start         (start),
    .abort         (abort),
    .start_address (start_address),
    .transfer_size (transfer_size),
    .busy          (busy),
    .done          (done),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  wr_t        exp_q[$];
  logic [7:0] order_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         last_ch = 0;
  int         mon_idx;
  int         drv_idx;
  bit         always_valid = 1'b1;
  logic [1:0] hold_valid = '0;
  int         done_pulses = 0;
  logic       done0_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int first_idx(input int c);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].ch == 8'(c)) return i;
    return -1;
  endfunction

  function automatic int pending(input int c);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].ch == 8'(c)) n++;
    return n;
  endfunction

  // Monitor pops expected writes; then the UART sources are driven for the next edge.
  always @(negedge clk) begin
    if (rstn) begin
      check("rd_en_onehot0", 32'($countones(bus.uart_read_enable) > 1), 0);
      if (bus.uart_read_enable[0]) last_ch = 0;
      else if (bus.uart_read_enable[1]) last_ch = 1;
      if (bus.memory_write_enable) begin
        mon_idx = first_idx(last_ch);
        if (mon_idx < 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: ch=%0d actual addr=0x%0h data=0x%0h expected no write",
                   last_ch, bus.memory_write_address, bus.memory_write_data);
        end else begin
          check("wr_addr", 32'(bus.memory_write_address), 32'(exp_q[mon_idx].addr));
          check("wr_data", 32'(bus.memory_write_data), 32'(exp_q[mon_idx].data));
          exp_q.delete(mon_idx);
        end
        if (order_q.size() > 0) begin
          check("rr_order", 32'(bus.memory_write_address), 32'(order_q[0]));
          void'(order_q.pop_front());
        end
      end
      if (done[0] && !done0_q) done_pulses++;
      done0_q = done[0];
    end
    for (int c = 0; c < 2; c++) begin
      drv_idx = first_idx(c);
      bus.uart_data[c*8 +: 8]  = (drv_idx >= 0) ? exp_q[drv_idx].data : 8'($urandom);
      bus.uart_data_valid[c]   = !hold_valid[c] && (always_valid || ($urandom_range(0, 99) < 60));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic program_ch(input int c, input logic [7:0] base, input int size,
                            input bit rnd, input logic [7:0] d0, input logic [7:0] step);
    wr_t e;
    start_address[c*8 +: 8] = base;
    transfer_size[c*8 +: 8] = 8'(size);
    for (int k = 0; k < size; k++) begin
      e.ch   = 8'(c);
      e.addr = base + 8'(k);
      e.data = rnd ? 8'($urandom) : d0 + 8'(k) * step;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    start = start | m;
    tick();
    start = start & ~m;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    tick();
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    start = '0;
    abort = '0;
    repeat (3) tick();
    exp_q.delete();
    order_q.delete();
    rstn = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] out_vec();
    return {9'b0, busy, done, bus.uart_read_enable, bus.memory_write_enable,
            bus.memory_write_address, bus.memory_write_data};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, s0, s1, gap;

    do_reset();
    check("reset_outputs", out_vec(), 0);

    // single byte
    program_ch(0, 8'h20, 1, 1'b0, 8'hAB, 8'h00);
    pulse_start(2'b01);
    check("a_busy", busy[0], 1);
    check("a_done_clear", done[0], 0);
    wait_drain(50);
    check("a_done", done[0], 1);
    check("a_busy_end", busy[0], 0);

    // two channels started together alternate strictly
    do_reset();
    program_ch(0, 8'h30, 4, 1'b1, 8'h00, 8'h00);
    program_ch(1, 8'h40, 4, 1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      order_q.push_back(8'h30 + 8'(k));
      order_q.push_back(8'h40 + 8'(k));
    end
    pulse_start(2'b11);
    wait_drain(100);
    check("b_order_left", order_q.size(), 0);
    check("b_done", done, 2'b11);
    check("b_busy", busy, 2'b00);

    // zero size completes at once without reading
    program_ch(1, 8'h00, 0, 1'b1, 8'h00, 8'h00);
    pulse_start(2'b10);
    check("c_size0_done", done[1], 1);
    check("c_size0_busy", busy[1], 0);
    cnt = 0;
    repeat (10) begin
      if (bus.uart_read_enable[1]) cnt++;
      tick();
    end
    check("c_size0_no_read", cnt, 0);

    // held start gives exactly one transfer
    program_ch(0, 8'h70, 1, 1'b1, 8'h00, 8'h00);
    start[0] = 1'b1;
    repeat (10) tick();
    start[0] = 1'b0;
    wait_drain(50);
    repeat (10) tick();
    check("c_held_done", done[0], 1);
    check("c_held_busy", busy[0], 0);

    // address wrap
    program_ch(0, 8'hFE, 4, 1'b0, 8'h11, 8'h11);
    pulse_start(2'b01);
    wait_drain(100);
    check("d_done", done[0], 1);

    // abort while waiting in READ
    program_ch(0, 8'h80, 3, 1'b1, 8'h00, 8'h00);
    pulse_start(2'b01);
    n = 0;
    while (pending(0) != 2 && n < 100) begin tick(); n++; end
    check("e_first_write", pending(0), 2);
    hold_valid[0] = 1'b1;
    n = 0;
    while (!bus.uart_read_enable[0] && n < 100) begin tick(); n++; end
    check("e_in_read", bus.uart_read_enable[0], 1);
    abort[0] = 1'b1;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].ch == 8'd0) exp_q.delete(i);
    tick();
    abort[0] = 1'b0;
    hold_valid[0] = 1'b0;
    check("e_abort_busy", busy[0], 0);
    check("e_abort_done", done[0], 0);
    repeat (20) tick();
    check("e_abort_idle", {busy[0], done[0], bus.uart_read_enable[0]}, 0);

    // reset mid-transfer
    program_ch(1, 8'h60, 4, 1'b1, 8'h00, 8'h00);
    pulse_start(2'b10);
    n = 0;
    while (pending(1) != 3 && n < 100) begin tick(); n++; end
    check("r_first_write", pending(1), 3);
    #1 rstn = 1'b0;
    #1 check("r_outputs_in_reset", out_vec(), 0);
    exp_q.delete();
    repeat (2) tick();
    rstn = 1'b1;
    repeat (20) tick();
    check("r_outputs_after", out_vec(), 0);

    // randomized two-channel traffic with stuttering UART valid
    always_valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      s0 = $urandom_range(1, 5);
      s1 = $urandom_range(1, 5);
      gap = $urandom_range(0, 4);
      program_ch(0, 8'($urandom), s0, 1'b1, 8'h00, 8'h00);
      program_ch(1, 8'($urandom), s1, 1'b1, 8'h00, 8'h00);
      if (gap == 0) begin
        pulse_start(2'b11);
        check("rnd_busy_both", busy, 2'b11);
        check("rnd_done_clr_both", done, 2'b00);
      end else begin
        pulse_start(2'b01);
        check("rnd_busy0", busy[0], 1);
        check("rnd_done_clr0", done[0], 0);
        repeat (gap) tick();
        pulse_start(2'b10);
        check("rnd_busy1", busy[1], 1);
        check("rnd_done_clr1", done[1], 0);
      end
      wait_drain(400);
      check("rnd_done", done, 2'b11);
      check("rnd_busy", busy, 2'b00);
    end

`ifdef DMA_CIRCULAR_EN
    do_reset();
    always_valid = 1'b1;
    circular = 2'b01;
    program_ch(0, 8'h50, 2, 1'b1, 8'h00, 8'h00);
    program_ch(0, 8'h50, 2, 1'b1, 8'h00, 8'h00);
    done_pulses = 0;
    pulse_start(2'b01);
    wait_drain(100);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    circular = 2'b00;
    repeat (10) tick();
    check("circ_done_pulses", done_pulses, 2);
    check("circ_busy_after_abort", busy[0], 0);
    check("circ_done_low", done[0], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_controller_mc.md
# dma_controller_mc

Multi-channel successor to the single-channel UART-to-memory DMA controller. NUM_CH independent channels, each fed by its own UART receive stream, share one memory write port through a byte-granular round-robin engine. Each channel has its own start/address/size programming, done and busy status, and abort. Sits between the per-channel UART receivers and the on-chip memory write port.

## Interface
- DATA_WIDTH, 8, byte/word width of UART data and memory data
- ADDR_WIDTH, 8, memory address width
- SIZE_WIDTH, 8, transfer-size counter width
- NUM_CH, 2, number of channels (≥2)

- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  NUM_CH  per-channel start; rising edge triggers
- abort  in  NUM_CH  per-channel abort, level-sampled
- start_address  in  NUM_CH*ADDR_WIDTH  per-channel base address, channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
- transfer_size  in  NUM_CH*SIZE_WIDTH  per-channel byte count, same packing
- uart_data  in  NUM_CH*DATA_WIDTH  per-channel UART data
- uart_data_valid  in  NUM_CH  per-channel data qualifier
- uart_read_enable  out  NUM_CH  per-channel read request, at most one bit high
- memory_write_address  out  ADDR_WIDTH  write address
- memory_write_data  out  DATA_WIDTH  write data
- memory_write_enable  out  1  one-cycle write strobe
- busy  out  NUM_CH  channel has a transfer in progress
- done  out  NUM_CH  sticky completion flag

## Operation
- Per-channel start edge detect (registered previous start). Edge while busy[c]=1 ignored. On accepted edge: latch base, size; offset=0; clear done[c]; busy[c]=1 if size≠0.
- size=0: no UART read; done[c]=1 the cycle after the sampling edge, busy stays 0.
- Channel requests service while busy[c]=1 and not aborting.
- Engine FSM: IDLE → READ → WRITE → IDLE.
  - IDLE: if any request, register grant = next requester at or after rr pointer (wraps), go READ.
  - READ: uart_read_enable[grant]=1; wait indefinitely; on uart_data_valid[grant]=1, capture uart_data[grant], go WRITE.
  - WRITE: memory_write_enable=1, address = base[grant] + offset[grant] (mod 2^ADDR_WIDTH, wraps), data = captured byte; at exit offset+1, remaining−1; rr pointer = grant+1; go IDLE.
- Last byte written: busy[c]←0, done[c]←1 at the WRITE exit edge.
- uart_data_valid on a channel without read enable is ignored (no capture).
- abort[c]=1: busy[c]←0 next edge, done[c] unchanged (stays 0). If engine is in READ for c, it returns to IDLE without writing. If in WRITE for c, that write completes, no done.
- Simultaneous start edge and abort on same channel: abort wins, channel stays idle.
- Reset (any time): all outputs 0, FSM IDLE, rr pointer 0, offsets/remaining 0, start-edge history 0; in-flight byte discarded.

## Timing
- Start edge sampled at edge E → busy[c]=1 after E → FSM leaves IDLE at E+1 → uart_read_enable high after E+1.
- Valid sampled at edge V in READ → memory_write_enable high for exactly one cycle after V.
- Minimum 3 cycles per byte (IDLE, READ, WRITE); done visible the cycle after the final write strobe.
- All outputs registered or decoded from registered state only; no input-to-output combinational path.

## Configuration
- DMA_CIRCULAR_EN defined: adds input circular (NUM_CH). Channel started with circular[c]=1 reloads offset=0 and remaining=size after its last byte, stays busy, and done[c] pulses high for one cycle per completed pass; ends only via abort or reset.
- Undefined: no circular port; every transfer is one-shot with sticky done.

## Structure
- Package dma_pkg: engine state enum (IDLE, READ, WRITE), channel-index width constant via $clog2(NUM_CH).
- Sub-module dma_rr_arbiter: NUM_CH request vector + pointer in, one-hot grant and index out, combinational.

## Test plan
- Ch0 base 0x20 size 1, UART byte 0xAB → one write 0xAB@0x20, done[0]=1, busy[0]=0.
- Ch0 base 0x30 and ch1 base 0x40, size 4 each, started same cycle, both UARTs always valid → writes alternate 0x30,0x40,0x31,0x41,…; both done after 8 strobes.
- Ch1 size 0 → done[1]=1 one cycle after start, uart_read_enable never high; start held high 10 cycles on ch0 size 1 → exactly one transfer.
- Ch0 base 0xFE size 4, data 0x11..0x44 → addresses 0xFE,0xFF,0x00,0x01.
- Ch0 size 3, abort after first write while in READ → no further strobes, busy[0]=0, done[0]=0; rstn pulse mid-transfer on ch1 → all outputs 0, no write after release.
- DMA_CIRCULAR_EN: ch0 base 0x50 size 2 circular → writes 0x50,0x51,0x50,0x51; done[0] pulses once per pass; abort stops it.
